// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - arbitrates one pmem port between I-cache and D-cache.
// Optional round-robin grant on simultaneous requests via ARBITER_ROUND_ROBIN_EN.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   d_req, i_req;

  assign d_req = d_pmem_read | d_pmem_write;
  assign i_req = i_pmem_read;

`ifdef ARBITER_ROUND_ROBIN_EN
  // 1 when the D-cache owned the most recent completed transaction.
  logic last_d_q, last_d_d;
`endif

  always_comb begin
    state_d = state_q;
`ifdef ARBITER_ROUND_ROBIN_EN
    last_d_d = last_d_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef ARBITER_ROUND_ROBIN_EN
        if (d_req && i_req) state_d = last_d_q ? SERVE_I : SERVE_D;
        else if (d_req)     state_d = SERVE_D;
        else if (i_req)     state_d = SERVE_I;
`else
        if (d_req)          state_d = SERVE_D;
        else if (i_req)     state_d = SERVE_I;
`endif
      end
      SERVE_I: begin
        if (pmem_resp) begin
          state_d = IDLE;
`ifdef ARBITER_ROUND_ROBIN_EN
          last_d_d = 1'b0;
`endif
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
`ifdef ARBITER_ROUND_ROBIN_EN
          last_d_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  // The registered grant steers the pmem port; requester fields pass through unregistered.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    case (state_q)
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
      end
      SERVE_D: begin
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_write   = d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
      end
      default: ;
    endcase
  end

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule
